// File: rtl/matmul_c_unloader_if.sv
// Row stream leaving the C unloader: valid/ready handshake with a last-row marker.
interface matmul_c_unloader_if #(
  parameter int unsigned DATA_WIDTH = 64
) ();
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_last;

  modport master (output out_data, output out_valid, output out_last, input out_ready);
  modport slave  (input out_data, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/matmul_c_unloader.sv
// Host-side reader of the matmul C result RAM: walks a strided row sequence and streams
// each row out, hiding the fixed one-cycle RAM read latency behind a 2-entry buffer.
module matmul_c_unloader #(
  parameter int unsigned DWIDTH            = 8,
  parameter int unsigned AWIDTH            = 11,
  parameter int unsigned MAT_MUL_SIZE      = 8,
  parameter int unsigned MASK_WIDTH        = 8,
  parameter int unsigned ADDR_STRIDE_WIDTH = 8,
  parameter int unsigned ROWS_WIDTH        = 4
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           start,
  input  logic [AWIDTH-1:0]              base_addr,
  input  logic [ADDR_STRIDE_WIDTH-1:0]   stride,
  input  logic [ROWS_WIDTH-1:0]          num_rows,
  output logic [AWIDTH-1:0]              bram_addr_c_ext,
  output logic [MASK_WIDTH-1:0]          bram_we_c_ext,
  output logic [MAT_MUL_SIZE*DWIDTH-1:0] bram_wdata_c_ext,
  input  logic [MAT_MUL_SIZE*DWIDTH-1:0] bram_rdata_c_ext,
  matmul_c_unloader_if.master            out_if,
  output logic                           busy,
  output logic                           done
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StRun    = 2'd1;
  localparam logic [1:0] StDrain  = 2'd2;
  localparam logic [1:0] StFinish = 2'd3;

  logic [1:0]                   state_q, state_d;
  logic [AWIDTH-1:0]            next_addr_q, addr_q;
  logic [ADDR_STRIDE_WIDTH-1:0] stride_q;
  logic [ROWS_WIDTH-1:0]        num_rows_q, row_issue_q, row_out_q, last_row;
  logic [MAT_MUL_SIZE*DWIDTH-1:0] buf0_q, buf1_q;
  logic [1:0]                   count_q;
  logic                         inflight_q;
  logic                         issue, push, pop;
  logic [2:0]                   occupancy;

  assign last_row = num_rows_q - ROWS_WIDTH'(1);
  assign push     = inflight_q;
  assign pop      = out_if.out_valid & out_if.out_ready;

  // Buffer slots already committed once this cycle's pop is accounted for.
  assign occupancy = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue     = (state_q == StRun) && (row_issue_q < num_rows_q) && (occupancy < 3'd2);

  // Address is presented combinationally in the issue cycle and held otherwise.
  assign bram_addr_c_ext  = issue ? next_addr_q : addr_q;
  assign bram_we_c_ext    = '0;
  assign bram_wdata_c_ext = '0;

  assign out_if.out_valid = (count_q != 2'd0);
  assign out_if.out_data  = buf0_q;
  assign out_if.out_last  = out_if.out_valid & (row_out_q == last_row);

  assign busy = (state_q == StRun) || (state_q == StDrain);
  assign done = (state_q == StFinish);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start) state_d = (num_rows == '0) ? StFinish : StRun;
      StRun:    if (issue && (row_issue_q == last_row)) state_d = StDrain;
      StDrain:  if (pop && (row_out_q == last_row)) state_d = StFinish;
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= StIdle;
      next_addr_q <= '0;
      addr_q      <= '0;
      stride_q    <= '0;
      num_rows_q  <= '0;
      row_issue_q <= '0;
      row_out_q   <= '0;
      buf0_q      <= '0;
      buf1_q      <= '0;
      count_q     <= 2'd0;
      inflight_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= issue;

      if ((state_q == StIdle) && start) begin
        next_addr_q <= base_addr;
        stride_q    <= stride;
        num_rows_q  <= num_rows;
        row_issue_q <= '0;
        row_out_q   <= '0;
      end

      if (issue) begin
        addr_q      <= next_addr_q;
        next_addr_q <= next_addr_q + AWIDTH'(stride_q);
        row_issue_q <= row_issue_q + ROWS_WIDTH'(1);
      end

      if (pop) row_out_q <= row_out_q + ROWS_WIDTH'(1);

      unique case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) buf0_q <= bram_rdata_c_ext;
          else                 buf1_q <= bram_rdata_c_ext;
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          buf0_q  <= buf1_q;
          count_q <= count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            buf0_q <= bram_rdata_c_ext;
          end else begin
            buf0_q <= buf1_q;
            buf1_q <= bram_rdata_c_ext;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
